// File: rtl/sisc_mem_arb_if.sv
// sisc_mem_arb_if: bundle of the fetch port, data port and memory port of
// the SISC memory arbiter.
//   slave  : the arbiter's view (requests and mem_rdata in; grants,
//            read returns and memory strobes out)
//   master : the requester/memory side's view (mirror of slave)
interface sisc_mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // data requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  // memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: single-port memory arbiter between instruction fetch and
// load/store. One access at a time; data wins ties except when fetch has
// been passed over DM_STREAK times in a row.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_f : asynchronous active-low reset
//   bus     : sisc_mem_arb_if.slave (fetch port, data port, memory port)
// Grants and the memory strobe are combinational in IDLE (zero-latency);
// a read parks the arbiter in WAIT for MEM_LAT cycles, the last of which
// carries the owner's rvalid. Writes never leave IDLE.
module sisc_mem_arb #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int DM_STREAK = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_f,
  sisc_mem_arb_if.slave  bus
);
  typedef enum logic { S_IDLE, S_WAIT } state_t;

  localparam logic [2:0] LAT        = 3'(MEM_LAT);
  localparam logic [2:0] STREAK_MAX = 3'(DM_STREAK);

  state_t     r_state;
  logic       r_owner;     // 0 = fetch, 1 = data
  logic [2:0] r_lat_cnt;
  logic [2:0] r_streak;    // consecutive data grants taken while fetch waited

  logic              w_idle, w_pick_dm, w_pick_if, w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Reset also masks the combinational grant path so nothing escapes
  // while the arbiter is held in reset.
  assign w_idle    = (r_state == S_IDLE) && i_rst_f;
  assign w_pick_dm = w_idle && bus.dm_req && (!bus.if_req || (r_streak != STREAK_MAX));
  assign w_pick_if = w_idle && bus.if_req && !w_pick_dm;
  assign w_last    = (r_state == S_WAIT) && (r_lat_cnt == 3'd1);

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    if (w_pick_dm) begin
      w_addr  = bus.dm_addr;
      w_wdata = bus.dm_wdata;
    end else if (w_pick_if) begin
      w_addr  = bus.if_addr;
    end
  end

  assign bus.if_gnt    = w_pick_if;
  assign bus.dm_gnt    = w_pick_dm;
  assign bus.mem_en    = w_pick_if || w_pick_dm;
  assign bus.mem_we    = w_pick_dm && bus.dm_we;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  assign bus.if_rvalid = w_last && !r_owner;
  assign bus.dm_rvalid = w_last &&  r_owner;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;

  always_ff @(posedge i_clk or negedge i_rst_f) begin
    if (!i_rst_f) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_lat_cnt <= 3'd0;
      r_streak  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_dm) begin
            // streak only grows while fetch is actually waiting
            r_streak <= bus.if_req ? r_streak + 3'd1 : 3'd0;
            if (!bus.dm_we) begin
              r_owner   <= 1'b1;
              r_lat_cnt <= LAT;
              r_state   <= S_WAIT;
            end
          end else if (w_pick_if) begin
            r_streak  <= 3'd0;
            r_owner   <= 1'b0;
            r_lat_cnt <= LAT;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
          if (r_lat_cnt == 3'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sisc_mem_arb.sv
module tb_sisc_mem_arb;
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b0;
  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  // u1: MEM_LAT=1 with a behavioural memory; u3: MEM_LAT=3, constant rdata
  sisc_mem_arb_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
  sisc_mem_arb_if #(.ADDR_W(16), .DATA_W(32)) b3 ();

  sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .DM_STREAK(2))
    u_dut1 (.i_clk(clk), .i_rst_f(rst1), .bus(b1));
  sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3), .DM_STREAK(2))
    u_dut3 (.i_clk(clk), .i_rst_f(rst3), .bus(b3));

  // one-cycle-latency memory: word i holds A5A5_00ii, word 0x10 holds 1234_5678
  logic [31:0] mem [256];
  logic [31:0] rd1;
  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'h1234_5678 : {16'hA5A5, 8'h00, 8'(i)};
      rd1 <= '0;
    end else if (b1.mem_en) begin
      if (b1.mem_we) mem[b1.mem_addr[7:0]] <= b1.mem_wdata;
      else           rd1 <= mem[b1.mem_addr[7:0]];
    end
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = 32'hC0DE_0003;

  typedef struct {
    logic        ir; logic [15:0] ia;
    logic        dr; logic dw; logic [15:0] da; logic [31:0] dd;
    logic        eig, edg, eiv, edv, een, ewe;
    logic [15:0] ea; logic [31:0] ewd; logic [31:0] erd;
    string       nm;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle3();
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
    b3.dm_addr = 0; b3.dm_wdata = 0;
  endtask

  initial begin
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
    b1.dm_addr = 0; b1.dm_wdata = 0;
    idle3();

    //            ir ia     dr dw da     dd            ig dg iv dv en we ea     wd            rd
    vq.push_back('{0, 0,     0, 0, 0,     0,            0, 0, 0, 0, 0, 0, 0,     0,            0,            "idle"});
    vq.push_back('{1, 'h10,  0, 0, 0,     0,            1, 0, 0, 0, 1, 0, 'h10,  0,            0,            "fetch_gnt"});
    vq.push_back('{0, 0,     0, 0, 0,     0,            0, 0, 1, 0, 0, 0, 0,     0,            'h12345678,   "fetch_rv"});
    vq.push_back('{0, 0,     1, 1, 'h40,  'hDEADBEEF,   0, 1, 0, 0, 1, 1, 'h40,  'hDEADBEEF,   0,            "wr_gnt"});
    vq.push_back('{0, 0,     1, 0, 'h40,  0,            0, 1, 0, 0, 1, 0, 'h40,  0,            0,            "rd_after_wr"});
    vq.push_back('{0, 0,     0, 0, 0,     0,            0, 0, 0, 1, 0, 0, 0,     0,            'hDEADBEEF,   "rd_rv"});
    vq.push_back('{1, 'h20,  1, 0, 'h44,  0,            0, 1, 0, 0, 1, 0, 'h44,  0,            0,            "both_dm1"});
    vq.push_back('{1, 'h20,  1, 0, 'h48,  0,            0, 0, 0, 1, 0, 0, 0,     0,            'hA5A50044,   "wait1"});
    vq.push_back('{1, 'h20,  1, 0, 'h48,  0,            0, 1, 0, 0, 1, 0, 'h48,  0,            0,            "both_dm2"});
    vq.push_back('{1, 'h20,  1, 0, 'h4C,  0,            0, 0, 0, 1, 0, 0, 0,     0,            'hA5A50048,   "wait2"});
    vq.push_back('{1, 'h20,  1, 0, 'h4C,  0,            1, 0, 0, 0, 1, 0, 'h20,  0,            0,            "guard_if1"});
    vq.push_back('{1, 'h24,  1, 0, 'h4C,  0,            0, 0, 1, 0, 0, 0, 0,     0,            'hA5A50020,   "wait3"});
    vq.push_back('{1, 'h24,  1, 0, 'h4C,  0,            0, 1, 0, 0, 1, 0, 'h4C,  0,            0,            "both_dm3"});
    vq.push_back('{1, 'h24,  1, 0, 'h50,  0,            0, 0, 0, 1, 0, 0, 0,     0,            'hA5A5004C,   "wait4"});
    vq.push_back('{1, 'h24,  1, 0, 'h50,  0,            0, 1, 0, 0, 1, 0, 'h50,  0,            0,            "both_dm4"});
    vq.push_back('{1, 'h24,  1, 0, 'h50,  0,            0, 0, 0, 1, 0, 0, 0,     0,            'hA5A50050,   "wait5"});
    vq.push_back('{1, 'h24,  1, 0, 'h50,  0,            1, 0, 0, 0, 1, 0, 'h24,  0,            0,            "guard_if2"});
    vq.push_back('{0, 0,     1, 0, 'h70,  0,            0, 0, 1, 0, 0, 0, 0,     0,            'hA5A50024,   "withdraw_wait"});
    vq.push_back('{0, 0,     0, 0, 0,     0,            0, 0, 0, 0, 0, 0, 0,     0,            0,            "withdrawn"});
    vq.push_back('{0, 0,     1, 1, 'h60,  'h11112222,   0, 1, 0, 0, 1, 1, 'h60,  'h11112222,   0,            "lone_wr"});
    vq.push_back('{1, 'h28,  1, 0, 'h64,  0,            0, 1, 0, 0, 1, 0, 'h64,  0,            0,            "both_dm5"});
    vq.push_back('{1, 'h28,  1, 1, 'h68,  'h33334444,   0, 0, 0, 1, 0, 0, 0,     0,            'hA5A50064,   "wait6"});
    vq.push_back('{1, 'h28,  1, 1, 'h68,  'h33334444,   0, 1, 0, 0, 1, 1, 'h68,  'h33334444,   0,            "both_wr6"});
    vq.push_back('{1, 'h28,  1, 1, 'h6C,  'h55556666,   1, 0, 0, 0, 1, 0, 'h28,  0,            0,            "guard_if3"});
    vq.push_back('{0, 0,     0, 0, 0,     0,            0, 0, 1, 0, 0, 0, 0,     0,            'hA5A50028,   "wait7"});

    // ---- reset state of u1
    #1 rst1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt",  32'(b1.if_gnt),    0);
    chk("rst_dm_gnt",  32'(b1.dm_gnt),    0);
    chk("rst_rvalid",  32'({b1.if_rvalid, b1.dm_rvalid}), 0);
    chk("rst_mem_en",  32'({b1.mem_en, b1.mem_we}), 0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 0);
    chk("rst_mem_wdata", b1.mem_wdata,    0);
    @(negedge clk) rst1 = 1'b1;

    // ---- table-driven sequence on u1 (one vector per cycle)
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      b1.if_req = vq[k].ir; b1.if_addr = vq[k].ia;
      b1.dm_req = vq[k].dr; b1.dm_we = vq[k].dw;
      b1.dm_addr = vq[k].da; b1.dm_wdata = vq[k].dd;
      #1;
      chk({vq[k].nm, ".if_gnt"},    32'(b1.if_gnt),    32'(vq[k].eig));
      chk({vq[k].nm, ".dm_gnt"},    32'(b1.dm_gnt),    32'(vq[k].edg));
      chk({vq[k].nm, ".if_rvalid"}, 32'(b1.if_rvalid), 32'(vq[k].eiv));
      chk({vq[k].nm, ".dm_rvalid"}, 32'(b1.dm_rvalid), 32'(vq[k].edv));
      chk({vq[k].nm, ".mem_en"},    32'(b1.mem_en),    32'(vq[k].een));
      chk({vq[k].nm, ".mem_we"},    32'(b1.mem_we),    32'(vq[k].ewe));
      chk({vq[k].nm, ".mem_addr"},  32'(b1.mem_addr),  32'(vq[k].ea));
      chk({vq[k].nm, ".mem_wdata"}, b1.mem_wdata,      vq[k].ewd);
      if (vq[k].eiv) chk({vq[k].nm, ".if_rdata"}, b1.if_rdata, vq[k].erd);
      if (vq[k].edv) chk({vq[k].nm, ".dm_rdata"}, b1.dm_rdata, vq[k].erd);
    end
    @(negedge clk);
    b1.if_req = 0; b1.dm_req = 0; b1.dm_we = 0;

    // ---- u3: MEM_LAT=3 read timing, then reset mid-WAIT
    @(negedge clk) rst3 = 1'b1;
    @(negedge clk);
    b3.if_req = 1; b3.if_addr = 16'h0100;
    #1;
    chk("l3_if_gnt",   32'(b3.if_gnt),   1);
    chk("l3_mem_addr", 32'(b3.mem_addr), 32'h0100);
    @(negedge clk) idle3();
    #1 chk("l3_rv_t1", 32'(b3.if_rvalid), 0);
    @(negedge clk);
    #1 chk("l3_rv_t2", 32'(b3.if_rvalid), 0);
    @(negedge clk);
    #1;
    chk("l3_rv_t3",    32'(b3.if_rvalid), 1);
    chk("l3_rdata_t3", b3.if_rdata,       32'hC0DE_0003);
    chk("l3_no_gnt_t3", 32'({b3.if_gnt, b3.dm_gnt, b3.mem_en}), 0);
    @(negedge clk);
    b3.dm_req = 1; b3.dm_addr = 16'h0200;
    #1 chk("l3_dm_gnt", 32'(b3.dm_gnt), 1);
    @(negedge clk) idle3();
    #1 chk("l3_dm_wait", 32'({b3.dm_rvalid, b3.mem_en}), 0);
    rst3 = 1'b0;
    #1;
    chk("rst3_gnt",    32'({b3.if_gnt, b3.dm_gnt}), 0);
    chk("rst3_rvalid", 32'({b3.if_rvalid, b3.dm_rvalid}), 0);
    chk("rst3_mem",    32'({b3.mem_en, b3.mem_we}), 0);
    chk("rst3_addr",   32'(b3.mem_addr), 0);
    chk("rst3_wdata",  b3.mem_wdata, 0);
    @(negedge clk) rst3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("rst3_no_rv%0d", c), 32'({b3.if_rvalid, b3.dm_rvalid}), 0);
      @(negedge clk);
    end
    b3.if_req = 1; b3.if_addr = 16'h0300;
    #1;
    chk("rst3_next_gnt",  32'(b3.if_gnt),   1);
    chk("rst3_next_addr", 32'(b3.mem_addr), 32'h0300);
    @(negedge clk) idle3();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sisc_mem_arb.md
# sisc_mem_arb

Single-port memory arbiter for the SISC core. Shares one synchronous memory between the instruction-fetch requester (PC/IM path) and the data requester (load/store path). Issues one access at a time, returns read data with a one-cycle valid pulse, and prioritises data accesses with a bounded-starvation guard for fetch.

## Interface
- ADDR_W, 16, address width (matches 16-bit PC)
- DATA_W, 32, data width (matches 32-bit IR/register file)
- MEM_LAT, 1, cycles from mem_en edge to valid mem_rdata; legal 1..7
- DM_STREAK, 2, max consecutive data grants while fetch waits; legal 1..7
- clk  in  1  system clock, rising edge
- rst_f  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted (one-cycle pulse)
- if_rvalid  out  1  fetch read data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request, held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data granted (one-cycle pulse)
- dm_rvalid  out  1  data read valid (one-cycle pulse; never for writes)
- dm_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, WAIT. Registers: state, owner (0 = fetch, 1 = data), lat_cnt (3 bits), streak (3 bits).
- IDLE arbitration (combinational): only if_req -> fetch; only dm_req -> data; both -> data unless streak == DM_STREAK, then fetch; neither -> no access.
- Grant cycle: winner's gnt = 1, mem_en = 1, mem_addr/mem_we/mem_wdata from winner; fetch always mem_we = 0, mem_wdata = 0. Loser gnt = 0, its req stays pending.
- Streak: on data grant with if_req = 1 -> streak + 1; data grant with if_req = 0 -> 0; fetch grant -> 0.
- Read grant: owner latched, lat_cnt = MEM_LAT, IDLE -> WAIT. Write grant: remain IDLE; no rvalid.
- WAIT: lat_cnt decrements each cycle; in cycle lat_cnt == 1, owner's rvalid = 1 and rdata = mem_rdata; next state IDLE. No grant, mem_en = 0 throughout WAIT.
- rdata outputs: mem_rdata passthrough to both ports; meaningful only when corresponding rvalid = 1.
- Requester deasserting req before gnt: legal; request withdrawn, no access.
- Outside grant cycles mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

## Timing
- Reset (rst_f = 0, async): state IDLE, owner 0, lat_cnt 0, streak 0; all gnt, rvalid, mem_en, mem_we = 0; mem_addr/mem_wdata = 0. Reset during WAIT aborts access; no rvalid issued.
- gnt and mem_en combinational from req in IDLE; same cycle as request (zero-latency grant).
- Read granted in cycle t: rvalid in cycle t + MEM_LAT; earliest next grant t + MEM_LAT + 1.
- Write granted in cycle t: earliest next grant t + 1 (back-to-back writes every cycle).
- rvalid is exactly one cycle, never coincides with a gnt.
- Requests arriving during WAIT are held and arbitrated on first IDLE cycle.

## Test plan
- Reset: assert rst_f = 0 mid-WAIT with MEM_LAT = 3 -> all outputs 0 immediately, no rvalid afterward, next if_req granted same cycle.
- Lone fetch: if_req = 1, if_addr = 16'h0010, memory returns 32'h1234_5678 at MEM_LAT = 1 -> if_gnt + mem_en at t, if_rvalid with if_rdata = 32'h1234_5678 at t + 1.
- Write then read: dm_we = 1, dm_addr = 16'h0040, dm_wdata = 32'hDEAD_BEEF; then read 16'h0040 -> write grant at t, read grant at t + 1, dm_rvalid at t + 2 with 32'hDEAD_BEEF, no dm_rvalid for write.
- Simultaneous first request: if_req = dm_req = 1 at IDLE -> dm_gnt = 1, if_gnt = 0, streak = 1.
- Starvation guard: DM_STREAK = 2, if_req held, dm_req reads continuous -> grants data, data, fetch, data, data, fetch…
- Withdrawn request: dm_req pulses 1 cycle during WAIT, then 0 -> no dm_gnt, no memory access issued.
